banco_registradores: RTL

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

---
 rtl/banco_registradores_if.sv | 39 +++
 rtl/banco_registradores.sv | 91 +++++++++
 2 files changed

// File: rtl/banco_registradores_if.sv
// Register bank bus interface.
// Groups every non-clock/non-reset signal of banco_registradores.
//   master : the side that issues writes/reads (testbench or upstream logic)
//   slave  : the register bank itself
// Signals:
//   load, addrWrite        addressed write strobe and target entry
//   push                   write at the circular head pointer
//   dataIn                 write data for load or push
//   addrReadA/B            read addresses for ports A and B
//   dataOutA/B, validA/B   registered read data and entry valid bits
//   head, count, full      circular pointer, number of valid entries, full flag
interface banco_registradores_if #(
  parameter int BITS = 63,
  parameter int ADDR = 3
);
  logic            load;
  logic [ADDR-1:0] addrWrite;
  logic            push;
  logic [BITS:0]   dataIn;
  logic [ADDR-1:0] addrReadA;
  logic [ADDR-1:0] addrReadB;
  logic [BITS:0]   dataOutA;
  logic [BITS:0]   dataOutB;
  logic            validA;
  logic            validB;
  logic [ADDR-1:0] head;
  logic [ADDR:0]   count;
  logic            full;

  modport master (
    output load, addrWrite, push, dataIn, addrReadA, addrReadB,
    input  dataOutA, dataOutB, validA, validB, head, count, full
  );

  modport slave (
    input  load, addrWrite, push, dataIn, addrReadA, addrReadB,
    output dataOutA, dataOutB, validA, validB, head, count, full
  );
endinterface

// File: rtl/banco_registradores.sv
// Register bank with DEPTH entries of BITS+1 bits, one valid bit per entry,
// an addressed write (load), a circular write (push) and two registered
// read ports with write-first bypass.
// Ports:
//   clk    single clock, all state changes on its rising edge
//   reset  synchronous active-high reset, clears every entry and output
//   bus    banco_registradores_if slave modport (see interface header)
module banco_registradores #(
  parameter int BITS  = 63,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input logic                  clk,
  input logic                  reset,
  banco_registradores_if.slave bus
);

  localparam logic [ADDR:0] FULL_CNT = (ADDR + 1)'(DEPTH);

  logic [BITS:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [ADDR-1:0]  head_q;
  logic [ADDR:0]    count_q;

  logic             we_p0;
  logic [ADDR-1:0]  waddr_p0;
  logic [BITS:0]    rda_p0, rdb_p0;
  logic             rva_p0, rvb_p0;

  logic [BITS:0]    rda_p1, rdb_p1;
  logic             vld_a_p1, vld_b_p1;

  // ---- stage p0: write decode and read mux with write-first bypass ----
  // push wins over load, so the write address follows head whenever push is set.
  always_comb begin
    we_p0    = bus.load | bus.push;
    waddr_p0 = bus.push ? head_q : bus.addrWrite;

    rva_p0 = vld_q[bus.addrReadA];
    rda_p0 = rva_p0 ? mem_q[bus.addrReadA] : '0;
    if (we_p0 && (bus.addrReadA == waddr_p0)) begin
      rda_p0 = bus.dataIn;
      rva_p0 = 1'b1;
    end

    rvb_p0 = vld_q[bus.addrReadB];
    rdb_p0 = rvb_p0 ? mem_q[bus.addrReadB] : '0;
    if (we_p0 && (bus.addrReadB == waddr_p0)) begin
      rdb_p0 = bus.dataIn;
      rvb_p0 = 1'b1;
    end
  end

  // ---- stage p1: storage update and registered read outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      head_q   <= '0;
      count_q  <= '0;
      rda_p1   <= '0;
      rdb_p1   <= '0;
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
    end else begin
      if (we_p0) begin
        mem_q[waddr_p0] <= bus.dataIn;
        vld_q[waddr_p0] <= 1'b1;
        // Only a first write to an entry adds to the population.
        if (!vld_q[waddr_p0] && (count_q != FULL_CNT))
          count_q <= count_q + (ADDR + 1)'(1);
        // ADDR bits cover exactly DEPTH entries, so the add wraps by itself.
        if (bus.push)
          head_q <= head_q + ADDR'(1);
      end
      rda_p1   <= rda_p0;
      rdb_p1   <= rdb_p0;
      vld_a_p1 <= rva_p0;
      vld_b_p1 <= rvb_p0;
    end
  end

  assign bus.dataOutA = rda_p1;
  assign bus.dataOutB = rdb_p1;
  assign bus.validA   = vld_a_p1;
  assign bus.validB   = vld_b_p1;
  assign bus.head     = head_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == FULL_CNT);

endmodule
